// File: rtl/seg7_pkg.sv
// Shared segment patterns, FSM state encoding and sizing helper
// for the signed seven-segment decoder.
package seg7_pkg;

    // Active-low segments, bit 6..0 = g,f,e,d,c,b,a
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CONVERT = 2'd1;
    localparam logic [1:0] ST_ENCODE  = 2'd2;

    // ceil(width*log10(2)) + 1 decimal digits, integer-only
    function automatic int bcd_digits(input int width);
        return (width * 30103 + 99999) / 100000 + 1;
    endfunction

endpackage

// File: rtl/seven_seg_signed_decoder_if.sv
// Request/result bundle for the signed seven-segment decoder.
// master drives the value and load, slave returns display state.
interface seven_seg_signed_decoder_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic [WIDTH-1:0]    value;
    logic                load;
    logic                busy;
    logic                done;
    logic                overflow;
    logic [6:0]          out_sign;
    logic [7*DIGITS-1:0] out_digits;

    modport master (
        output value,
        output load,
        input  busy,
        input  done,
        input  overflow,
        input  out_sign,
        input  out_digits
    );

    modport slave (
        input  value,
        input  load,
        output busy,
        output done,
        output overflow,
        output out_sign,
        output out_digits
    );
endinterface

// File: rtl/bcd_to_seg7.sv
// One BCD digit to active-low seven-segment pattern.
// blank forces all segments off; non-decimal codes also blank.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    // Pattern lookup with blank override
    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/seven_seg_signed_decoder.sv
// Signed binary to multi-digit seven-segment display driver
// using a sequential double-dabble conversion.
module seven_seg_signed_decoder
    import seg7_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 3,
    parameter int BLANK_LZ = 1
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [WIDTH-1:0]    In,
    input  logic                Load,
    output logic                Busy,
    output logic                Done,
    output logic                Overflow,
    output logic [6:0]          OutSign,
    output logic [7*DIGITS-1:0] OutDigits
);

    localparam int NEED = bcd_digits(WIDTH);
    // BCD register also covers every displayed digit
    localparam int ND   = (NEED > DIGITS) ? NEED : DIGITS;

    logic [1:0]          state;
    logic [4:0]          cnt;
    logic                load_q;
    logic [WIDTH-1:0]    in_q;
    logic [WIDTH-1:0]    in_abs;
    logic                sign;
    logic [WIDTH-1:0]    mag;
    logic [4*ND-1:0]     bcd;
    logic [4*ND-1:0]     bcd_adj;
    logic                ovf;
    logic [DIGITS-1:0]   blank;
    logic [7*DIGITS-1:0] segs;
    logic [7*DIGITS-1:0] segs_final;

    assign Busy = (state != ST_IDLE);

    // Most-negative input maps to 2^(WIDTH-1) as unsigned
    assign in_abs = in_q[WIDTH-1] ? (~in_q + WIDTH'(1)) : in_q;

    // Add-3 correction for every BCD digit before the shift
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < ND; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            else
                bcd_adj[4*i +: 4] = bcd[4*i +: 4];
        end
    end

    // Any nonzero digit beyond the display means overflow
    always_comb begin
        ovf = 1'b0;
        for (int i = DIGITS; i < ND; i++) begin
            if (bcd[4*i +: 4] != 4'd0)
                ovf = 1'b1;
        end
    end

    // Leading-zero blanking, scanned from the top digit down
    always_comb begin
        logic seen;
        seen  = 1'b0;
        blank = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (bcd[4*i +: 4] != 4'd0)
                seen = 1'b1;
            blank[i] = (BLANK_LZ != 0) && (i != 0) && !seen;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bcd_to_seg7 u_seg (
            .digit (bcd[4*g +: 4]),
            .blank (blank[g]),
            .seg   (segs[7*g +: 7])
        );
    end

    assign segs_final = ovf ? {DIGITS{SEG_MINUS}} : segs;

    // Request capture; loads arriving while busy are dropped
    always_ff @(posedge Clock) begin
        if (Reset) begin
            load_q <= 1'b0;
            in_q   <= '0;
        end else begin
            load_q <= Load && !Busy;
            if (Load && !Busy)
                in_q <= In;
        end
    end

    // Conversion FSM and registered display outputs
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            sign      <= 1'b0;
            mag       <= '0;
            bcd       <= '0;
            Done      <= 1'b0;
            Overflow  <= 1'b0;
            OutSign   <= SEG_BLANK;
            OutDigits <= {DIGITS{SEG_BLANK}};
        end else begin
            Done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load_q) begin
                        sign  <= in_q[WIDTH-1];
                        mag   <= in_abs;
                        bcd   <= '0;
                        cnt   <= '0;
                        state <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    bcd <= {bcd_adj[4*ND-2:0], mag[WIDTH-1]};
                    mag <= {mag[WIDTH-2:0], 1'b0};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'(WIDTH - 1))
                        state <= ST_ENCODE;
                end
                ST_ENCODE: begin
                    Done      <= 1'b1;
                    Overflow  <= ovf;
                    OutSign   <= sign ? SEG_MINUS : SEG_BLANK;
                    OutDigits <= segs_final;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seven_seg_signed_decoder.sv
// Bench for seven_seg_signed_decoder: table vectors through a
// scoreboard on two instances (3 and 2 digits) plus corner cases.
module tb_seven_seg_signed_decoder;

    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] MN = 7'b0111111;
    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;

    typedef struct {
        logic [7:0]  value;
        logic [6:0]  sign;
        logic [20:0] digits;
        logic        ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   done1_cnt = 0;
    int   done2_cnt = 0;
    vec_t q1[$];
    vec_t q2[$];
    vec_t tab1[9];
    vec_t tab2[5];
    vec_t e1, e2;

    always #5 clk = ~clk;

    seven_seg_signed_decoder_if #(.WIDTH(8), .DIGITS(3)) v1 ();
    seven_seg_signed_decoder_if #(.WIDTH(8), .DIGITS(2)) v2 ();

    seven_seg_signed_decoder #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(1)) dut1 (
        .Clock(clk), .Reset(rst), .In(v1.value), .Load(v1.load),
        .Busy(v1.busy), .Done(v1.done), .Overflow(v1.overflow),
        .OutSign(v1.out_sign), .OutDigits(v1.out_digits)
    );

    seven_seg_signed_decoder #(.WIDTH(8), .DIGITS(2), .BLANK_LZ(1)) dut2 (
        .Clock(clk), .Reset(rst), .In(v2.value), .Load(v2.load),
        .Busy(v2.busy), .Done(v2.done), .Overflow(v2.overflow),
        .OutSign(v2.out_sign), .OutDigits(v2.out_digits)
    );

    wire done_m = sel ? v2.done : v1.done;
    wire busy_m = sel ? v2.busy : v1.busy;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [7:0] v, input logic l);
        if (s) begin
            v2.value = v;
            v2.load  = l;
        end else begin
            v1.value = v;
            v1.load  = l;
        end
    endtask

    task automatic push(input logic s, input vec_t e);
        if (s) q2.push_back(e);
        else   q1.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compare against the oldest expected on each Done
    always @(negedge clk) begin
        if (!rst && v1.done) begin
            done1_cnt++;
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut1_unexpected_done: got done expected none");
            end else begin
                e1 = q1.pop_front();
                check("dut1_sign", v1.out_sign, e1.sign);
                check("dut1_digits", v1.out_digits, e1.digits);
                check("dut1_ovf", v1.overflow, e1.ovf);
            end
        end
        if (!rst && v2.done) begin
            done2_cnt++;
            if (q2.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut2_unexpected_done: got done expected none");
            end else begin
                e2 = q2.pop_front();
                check("dut2_sign", v2.out_sign, e2.sign);
                check("dut2_digits", v2.out_digits, e2.digits);
                check("dut2_ovf", v2.overflow, e2.ovf);
            end
        end
    end

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done_m && cyc < 20) begin
            tick();
            cyc++;
        end
    endtask

    // One conversion with latency and Busy-window checks
    task automatic convert(input logic s, input vec_t e);
        int cyc;
        int bad;
        sel = s;
        drive(s, e.value, 1'b1);
        push(s, e);
        tick();
        drive(s, e.value, 1'b0);
        check("busy_before_k1", busy_m, 0);
        cyc = 0;
        bad = 0;
        do begin
            tick();
            cyc++;
            if (!done_m && !busy_m) bad++;
        end while (!done_m && cyc < 20);
        check("latency", cyc, 10);
        check("busy_window", bad, 0);
        check("busy_low_at_done", busy_m, 0);
        tick();
        check("done_one_cycle", done_m, 0);
    endtask

    initial begin
        int cyc;
        int snap;

        tab1[0] = '{8'd45,  BL, {BL, S4, S5}, 1'b0};
        tab1[1] = '{8'hF7,  MN, {BL, BL, S9}, 1'b0};
        tab1[2] = '{8'h80,  MN, {S1, S2, S8}, 1'b0};
        tab1[3] = '{8'd0,   BL, {BL, BL, S0}, 1'b0};
        tab1[4] = '{8'd127, BL, {S1, S2, S7}, 1'b0};
        tab1[5] = '{8'd100, BL, {S1, S0, S0}, 1'b0};
        tab1[6] = '{8'hFF,  MN, {BL, BL, S1}, 1'b0};
        tab1[7] = '{8'd10,  BL, {BL, S1, S0}, 1'b0};
        tab1[8] = '{8'h96,  MN, {S1, S0, S6}, 1'b0};

        tab2[0] = '{8'd100, BL, {7'h0, MN, MN}, 1'b1};
        tab2[1] = '{8'd0,   BL, {7'h0, BL, S0}, 1'b0};
        tab2[2] = '{8'h9C,  MN, {7'h0, MN, MN}, 1'b1};
        tab2[3] = '{8'd99,  BL, {7'h0, S9, S9}, 1'b0};
        tab2[4] = '{8'h80,  MN, {7'h0, MN, MN}, 1'b1};

        drive(0, 8'd0, 1'b0);
        drive(1, 8'd0, 1'b0);

        // Reset held two cycles
        rst = 1'b1;
        tick();
        tick();
        check("rst_busy", v1.busy, 0);
        check("rst_done", v1.done, 0);
        check("rst_ovf", v1.overflow, 0);
        check("rst_sign", v1.out_sign, BL);
        check("rst_digits", v1.out_digits, {BL, BL, BL});
        check("rst_digits2", v2.out_digits, {BL, BL});
        rst = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) convert(0, tab1[i]);
        for (int i = 0; i < 5; i++) convert(1, tab2[i]);

        // Second Load three cycles into a conversion is ignored
        sel = 0;
        snap = done1_cnt;
        drive(0, 8'd45, 1'b1);
        push(0, tab1[0]);
        tick();
        drive(0, 8'd45, 1'b0);
        repeat (3) tick();
        drive(0, 8'h96, 1'b1);
        tick();
        drive(0, 8'h96, 1'b0);
        repeat (30) tick();
        check("ignored_load_done_count", done1_cnt - snap, 1);

        // Load in the Done cycle starts a new conversion
        drive(0, tab1[7].value, 1'b1);
        push(0, tab1[7]);
        tick();
        drive(0, tab1[7].value, 1'b0);
        wait_done(cyc);
        check("first_latency", cyc, 10);
        drive(0, tab1[6].value, 1'b1);
        push(0, tab1[6]);
        tick();
        drive(0, tab1[6].value, 1'b0);
        wait_done(cyc);
        check("b2b_latency", cyc, 10);
        tick();

        // Outputs hold during a conversion and while idle
        drive(0, tab1[4].value, 1'b1);
        push(0, tab1[4]);
        tick();
        drive(0, 8'd0, 1'b0);
        repeat (5) tick();
        check("hold_sign_busy", v1.out_sign, MN);
        check("hold_digits_busy", v1.out_digits, {BL, BL, S1});
        wait_done(cyc);
        tick();
        drive(0, 8'hF7, 1'b0);
        repeat (3) tick();
        check("hold_sign_idle", v1.out_sign, BL);
        check("hold_digits_idle", v1.out_digits, {S1, S2, S7});

        // Reset in the middle of a conversion
        drive(0, 8'd127, 1'b1);
        tick();
        drive(0, 8'd127, 1'b0);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        check("midrst_busy", v1.busy, 0);
        check("midrst_done", v1.done, 0);
        check("midrst_ovf", v1.overflow, 0);
        check("midrst_sign", v1.out_sign, BL);
        check("midrst_digits", v1.out_digits, {BL, BL, BL});
        rst = 1'b0;
        snap = done1_cnt;
        repeat (15) tick();
        check("midrst_no_done", done1_cnt - snap, 0);
        convert(0, tab1[0]);

        repeat (3) tick();
        check("q1_drained", q1.size(), 0);
        check("q2_drained", q2.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
